// File: rtl/polara_noc_test_sequencer_pkg.sv
// Shared types and constants for the Polara NoC loopback test sequencer.
package polara_noc_test_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Error codes reported on err_code.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_SEQ     = 2'd2;
  localparam logic [1:0] ERR_CHIPRST = 2'd3;

  // MSHR field of the flit header carries the sequence tag.
  localparam int MSHR_LSB = 6;
  localparam int MSHR_MSB = 13;

  // One-hot channel encodings, bit0 = noc1.
  localparam logic [2:0] CH_NONE = 3'b000;
  localparam logic [2:0] CH_NOC1 = 3'b001;
  localparam logic [2:0] CH_NOC2 = 3'b010;
  localparam logic [2:0] CH_NOC3 = 3'b100;

  // Channel number (1..3) to one-hot; 0 maps to no channel.
  function automatic logic [2:0] chan_onehot(input logic [1:0] chan);
    case (chan)
      2'd1:    return CH_NOC1;
      2'd2:    return CH_NOC2;
      2'd3:    return CH_NOC3;
      default: return CH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/polara_noc_test_sequencer_if.sv
// NoC port bundle between the chipset-side sequencer and the chip.
//
// Handshake: a flit moves on a channel in any cycle where that channel's
// valid and ready are both high at the rising clock edge. tx_val/rx_rdy are
// one-hot (bit0 = noc1). The sender keeps valid and data stable until the
// transfer happens; the receiver may raise or drop ready freely.
interface polara_noc_test_sequencer_if #(
  parameter int W = 64
);
  logic [W-1:0]   tx_data;
  logic [2:0]     tx_val;
  logic [2:0]     tx_rdy;
  logic [3*W-1:0] rx_data;
  logic [2:0]     rx_val;
  logic [2:0]     rx_rdy;

  // Sequencer side.
  modport master (
    output tx_data, tx_val, rx_rdy,
    input  tx_rdy, rx_data, rx_val
  );

  // Chip side.
  modport slave (
    input  tx_data, tx_val, rx_rdy,
    output tx_rdy, rx_data, rx_val
  );
endinterface

// File: rtl/polara_rx_prio_sel.sv
// Fixed-priority (noc1 > noc2 > noc3) selection of returned flits.
module polara_rx_prio_sel
  import polara_noc_test_pkg::*;
#(
  parameter int W = 64
) (
  input  logic           en,
  input  logic [2:0]     rx_val,
  input  logic [3*W-1:0] rx_data,
  output logic [2:0]     rx_rdy,
  output logic [W-1:0]   sel_data,
  output logic           acc
);

  // Pick the lowest-numbered valid channel; ready only while enabled.
  always_comb begin
    rx_rdy   = CH_NONE;
    sel_data = rx_data[W-1:0];
    if (rx_val[0]) begin
      rx_rdy   = CH_NOC1;
      sel_data = rx_data[W-1:0];
    end else if (rx_val[1]) begin
      rx_rdy   = CH_NOC2;
      sel_data = rx_data[2*W-1:W];
    end else if (rx_val[2]) begin
      rx_rdy   = CH_NOC3;
      sel_data = rx_data[3*W-1:2*W];
    end
    if (!en) begin
      rx_rdy = CH_NONE;
    end
    acc = |rx_rdy;
  end

endmodule

// File: rtl/polara_noc_test_sequencer.sv
// NoC loopback test sequencer: injects tagged single-flit packets into the
// chip and checks that the echoed flits come back in order.
module polara_noc_test_sequencer
  import polara_noc_test_pkg::*;
#(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int NUM_PKTS       = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic                      chipset_clk,
  input  logic                      chipset_rst_n,
  input  logic                      chip_rst_n,
  input  logic                      start,
  input  logic [1:0]                chan_sel,
  input  logic [NOC_DATA_WIDTH-1:0] hdr_tmpl,
  polara_noc_test_sequencer_if.master noc,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [1:0]                err_code,
  output logic [CNT_W-1:0]          tx_cnt,
  output logic [CNT_W-1:0]          rx_cnt,
  output seq_state_e                dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_PKTS - 1);
  localparam logic [CNT_W-1:0] PKT_TOTAL = CNT_W'(NUM_PKTS);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [1:0]       rr_q, rr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic                      in_send;
  logic                      rx_en;
  logic                      tx_acc;
  logic                      rx_acc;
  logic                      tag_ok;
  logic [1:0]                chan_idx;
  logic [2:0]                tx_sel;
  logic [2:0]                tx_val_c;
  logic [2:0]                rx_rdy_c;
  logic [NOC_DATA_WIDTH-1:0] tx_flit;
  logic [NOC_DATA_WIDTH-1:0] rx_flit;
  logic                      unused_rx_bits;

  // Outbound flit and valid; chip reset gates valid in the same cycle.
  always_comb begin
    chan_idx = (chan_q == 2'd0) ? (rr_q + 2'd1) : chan_q;
    tx_sel   = chan_onehot(chan_idx);
    tx_flit  = hdr_tmpl;
    tx_flit[MSHR_MSB:MSHR_LSB] = tx_cnt_q[7:0];
    in_send  = (state_q == ST_SEND);
    tx_val_c = (in_send && chip_rst_n) ? tx_sel : CH_NONE;
    tx_acc   = |(tx_val_c & noc.tx_rdy);
    rx_en    = chip_rst_n &&
               (in_send || (state_q == ST_DRAIN && rx_cnt_q != PKT_TOTAL));
  end

  assign noc.tx_val  = tx_val_c;
  assign noc.tx_data = in_send ? tx_flit : '0;
  assign noc.rx_rdy  = rx_rdy_c;

  polara_rx_prio_sel #(
    .W (NOC_DATA_WIDTH)
  ) u_rx_sel (
    .en       (rx_en),
    .rx_val   (noc.rx_val),
    .rx_data  (noc.rx_data),
    .rx_rdy   (rx_rdy_c),
    .sel_data (rx_flit),
    .acc      (rx_acc)
  );

  assign tag_ok = (rx_flit[MSHR_MSB:MSHR_LSB] == rx_cnt_q[7:0]);
  // Only the tag field of a returned flit matters for the check.
  assign unused_rx_bits = ^{rx_flit[NOC_DATA_WIDTH-1:MSHR_MSB+1],
                            rx_flit[MSHR_LSB-1:0]};

  // Next-state and registered-output computation for the run FSM.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    rr_d     = rr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    to_d     = to_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (chip_rst_n) begin
            state_d  = ST_SEND;
            chan_d   = chan_sel;
            rr_d     = 2'd0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            err_d    = ERR_NONE;
            tx_cnt_d = '0;
            rx_cnt_d = '0;
            to_d     = '0;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = ERR_CHIPRST;
          end
        end
      end
      ST_SEND, ST_DRAIN: begin
        if (!chip_rst_n) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = ERR_CHIPRST;
        end else begin
          if (tx_acc) begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
            rr_d     = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
            if (tx_cnt_q == LAST_IDX) begin
              state_d = ST_DRAIN;
            end
          end
          if (rx_acc && tag_ok) begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
          if (tx_acc || rx_acc) begin
            to_d = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
          if (rx_acc && !tag_ok) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = ERR_SEQ;
          end else if (!tx_acc && !rx_acc && to_q == TO_LIMIT) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = ERR_TIMEOUT;
          end else if (state_q == ST_DRAIN && rx_cnt_q == PKT_TOTAL) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
            err_d   = ERR_NONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      state_q  <= ST_IDLE;
      chan_q   <= 2'd0;
      rr_q     <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= ERR_NONE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      to_q     <= to_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_code  = err_q;
  assign tx_cnt    = tx_cnt_q;
  assign rx_cnt    = rx_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_polara_noc_test_sequencer.sv
// Bench for the NoC loopback test sequencer: a chip model echoes accepted
// flits back on random channels while a reference model tracks the expected
// flit stream, counters and run outcome.
module tb_polara_noc_test_sequencer;
  import polara_noc_test_pkg::*;

  localparam int W     = 64;
  localparam int N     = 6;
  localparam int TO    = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             chip_rst_n;
  logic             start;
  logic [1:0]       chan_sel;
  logic [W-1:0]     hdr_tmpl;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  seq_state_e       dbg_state;

  polara_noc_test_sequencer_if #(.W(W)) noc_if ();

  polara_noc_test_sequencer #(
    .NOC_DATA_WIDTH (W),
    .NUM_PKTS       (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNT_W)
  ) dut (
    .chipset_clk   (clk),
    .chipset_rst_n (rst_n),
    .chip_rst_n    (chip_rst_n),
    .start         (start),
    .chan_sel      (chan_sel),
    .hdr_tmpl      (hdr_tmpl),
    .noc           (noc_if),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_code      (err_code),
    .tx_cnt        (tx_cnt),
    .rx_cnt        (rx_cnt),
    .dbg_state     (dbg_state)
  );

  // Scoreboard state
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_ch_q[$];
  logic [W-1:0] echo_q[$];
  int           n_tx;
  int           n_rx;
  int           since_tx;
  int           skip_idx;
  int           stall_at;
  int           stall_left;
  bit           mism;
  bit           echo_en;
  bit           all_rdy;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lowest set bit: the highest-priority valid channel.
  function automatic logic [2:0] lowbit(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  // Chip model: drive tx_rdy and present the oldest pending echo.
  task automatic drive_chip();
    logic [2:0] head_ch;
    logic [2:0] hi_mask;
    int c;
    head_ch = (exp_ch_q.size() > 0) ? exp_ch_q[0] : 3'b000;
    if (all_rdy) begin
      noc_if.tx_rdy = 3'b111;
    end else begin
      noc_if.tx_rdy = 3'($urandom_range(0, 7)) & ~head_ch;
      if ($urandom_range(0, 3) != 0) noc_if.tx_rdy = noc_if.tx_rdy | head_ch;
    end
    if (stall_left > 0 && n_tx == stall_at) begin
      noc_if.tx_rdy = noc_if.tx_rdy & ~head_ch;
      stall_left--;
    end
    noc_if.rx_val  = 3'b000;
    noc_if.rx_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (echo_en && echo_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      c = $urandom_range(0, 2);
      hi_mask = ~((3'b010 << c) - 3'b001);
      noc_if.rx_val = (3'b001 << c) | (3'($urandom_range(0, 7)) & hi_mask);
      noc_if.rx_data[c*W +: W] = echo_q[0];
    end
  endtask

  // One clock cycle: drive, check outputs, update model, advance.
  task automatic tick();
    logic [2:0]   exp_rdy;
    logic [W-1:0] got;
    @(negedge clk);
    since_tx++;
    drive_chip();
    #1;
    if (busy) begin
      chk("tx_cnt", 64'(tx_cnt), 64'(n_tx));
      chk("rx_cnt", 64'(rx_cnt), 64'(n_rx));
    end
    exp_rdy = (busy && chip_rst_n) ? lowbit(noc_if.rx_val) : 3'b000;
    chk("rx_rdy", 64'(noc_if.rx_rdy), 64'(exp_rdy));
    if (!busy || !chip_rst_n || exp_q.size() == 0) begin
      chk("tx_val_idle", 64'(noc_if.tx_val), 64'(0));
    end else begin
      chk("tx_val", 64'(noc_if.tx_val), 64'(exp_ch_q[0]));
      chk("tx_data", 64'(noc_if.tx_data), 64'(exp_q[0]));
    end
    if ((noc_if.tx_val & noc_if.tx_rdy) != 3'b000 && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      void'(exp_ch_q.pop_front());
      if (n_tx != skip_idx) echo_q.push_back(got);
      n_tx++;
      since_tx = 0;
    end
    if ((noc_if.rx_val & noc_if.rx_rdy) != 3'b000 && echo_q.size() > 0) begin
      got = echo_q.pop_front();
      if (got[13:6] == 8'(n_rx)) n_rx++;
      else mism = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Build the expected flit stream for a run and pulse start.
  task automatic start_run(input logic [1:0] sel);
    logic [W-1:0] flit;
    int ch;
    exp_q.delete();
    exp_ch_q.delete();
    echo_q.delete();
    n_tx = 0;
    n_rx = 0;
    mism = 1'b0;
    hdr_tmpl = {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      ch = (sel == 2'd0) ? (i % 3) + 1 : int'(sel);
      flit = hdr_tmpl;
      flit[13:6] = 8'(i);
      exp_q.push_back(flit);
      exp_ch_q.push_back(3'(1 << (ch - 1)));
    end
    chan_sel = sel;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_done_clr", 64'(done), 64'(0));
  endtask

  task automatic run_until_done(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done) break;
    end
    chk("done_reached", 64'(done), 64'(1));
  endtask

  task automatic check_pass(input string tag);
    chk({tag, "_pass"}, 64'(pass), 64'(mism ? 0 : 1));
    chk({tag, "_err"}, 64'(err_code), 64'(mism ? ERR_SEQ : ERR_NONE));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_tx_cnt"}, 64'(tx_cnt), 64'(N));
    chk({tag, "_rx_cnt"}, 64'(rx_cnt), 64'(n_rx));
    chk({tag, "_rx_all"}, 64'(n_rx), 64'(N));
  endtask

  initial begin
    rst_n = 1'b0;
    chip_rst_n = 1'b1;
    start = 1'b0;
    chan_sel = 2'd0;
    hdr_tmpl = '0;
    noc_if.tx_rdy = 3'b000;
    noc_if.rx_val = 3'b000;
    noc_if.rx_data = '0;
    echo_en = 1'b1;
    all_rdy = 1'b0;
    skip_idx = -1;
    stall_at = 0;
    stall_left = 0;
    n_tx = 0;
    n_rx = 0;
    since_tx = 0;
    mism = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_err", 64'(err_code), 64'(0));
    chk("rst_tx_cnt", 64'(tx_cnt), 64'(0));
    chk("rst_rx_cnt", 64'(rx_cnt), 64'(0));
    chk("rst_tx_val", 64'(noc_if.tx_val), 64'(0));
    chk("rst_tx_data", 64'(noc_if.tx_data), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Fixed noc2, random readiness
    start_run(2'd2);
    run_until_done(200);
    check_pass("fixed2");

    // Start while the chip is held in reset
    chip_rst_n = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("chiprst_start_done", 64'(done), 64'(1));
    chk("chiprst_start_err", 64'(err_code), 64'(ERR_CHIPRST));
    chk("chiprst_start_busy", 64'(busy), 64'(0));
    chip_rst_n = 1'b1;

    // Round-robin, all ready, with an ignored start mid-run
    all_rdy = 1'b1;
    start_run(2'd0);
    repeat (2) tick();
    start = 1'b1;
    chan_sel = 2'd3;
    tick();
    start = 1'b0;
    run_until_done(200);
    check_pass("rr");

    // Flit 2 stalled for 5 cycles on noc1
    stall_at = 2;
    stall_left = 5;
    start_run(2'd1);
    run_until_done(200);
    chk("stall_consumed", 64'(stall_left), 64'(0));
    check_pass("stall");

    // Echo skips flit 1 -> sequence error
    skip_idx = 1;
    start_run(2'd3);
    run_until_done(200);
    chk("seq_mism_seen", 64'(mism), 64'(1));
    chk("seq_err", 64'(err_code), 64'(ERR_SEQ));
    chk("seq_pass", 64'(pass), 64'(0));
    chk("seq_rx_cnt", 64'(rx_cnt), 64'(1));
    skip_idx = -1;

    // No echoes -> timeout TO cycles after the last accept
    echo_en = 1'b0;
    start_run(2'd1);
    run_until_done(200);
    chk("to_err", 64'(err_code), 64'(ERR_TIMEOUT));
    chk("to_pass", 64'(pass), 64'(0));
    chk("to_cycles", 64'(since_tx), 64'(TO));
    chk("to_tx_cnt", 64'(tx_cnt), 64'(N));
    chk("to_rx_cnt", 64'(rx_cnt), 64'(0));
    echo_en = 1'b1;

    // Chip reset during SEND
    start_run(2'd0);
    for (int i = 0; i < 20 && n_tx < 2; i++) tick();
    chip_rst_n = 1'b0;
    #1;
    chk("chiprst_tx_val", 64'(noc_if.tx_val), 64'(0));
    chk("chiprst_rx_rdy", 64'(noc_if.rx_rdy), 64'(0));
    chk("chiprst_busy_same", 64'(busy), 64'(1));
    tick();
    chk("chiprst_done", 64'(done), 64'(1));
    chk("chiprst_err", 64'(err_code), 64'(ERR_CHIPRST));
    chk("chiprst_pass", 64'(pass), 64'(0));
    chip_rst_n = 1'b1;

    // Asynchronous reset mid-run
    all_rdy = 1'b0;
    start_run(2'd2);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_tx_val", 64'(noc_if.tx_val), 64'(0));
    chk("arst_tx_cnt", 64'(tx_cnt), 64'(0));
    chk("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_ch_q.delete();
    echo_q.delete();
    n_tx = 0;
    n_rx = 0;
    tick();

    // Randomized runs
    repeat (4) begin
      start_run(2'($urandom_range(0, 3)));
      run_until_done(400);
      check_pass("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/polara_noc_test_sequencer.md
Name: polara_noc_test_sequencer

Overview:
Chipset-side controller that runs a NoC loopback test campaign into the Polara chip.
- On start, injects NUM_PKTS single-flit packets on one selected chip NoC channel, or round-robin over noc1..noc3.
- Tags each flit with a sequence number and checks that returned flits arrive in order.
- Reports pass/fail with an error code.
- Sits between the chipset FPGA glue (switch/GPIO control) and the chipset_intf_* / intf_chipset_* NoC ports.

Parameters:
NOC_DATA_WIDTH, 64, flit width
NUM_PKTS, 16, packets per run (1..255)
TIMEOUT_CYCLES, 1024, idle cycles without any tx/rx acceptance before failing
CNT_W, 8, width of tx_cnt/rx_cnt

Ports:
chipset_clk  in  1  clock
chipset_rst_n  in  1  reset; asynchronous assert, active-low
chip_rst_n  in  1  chip reset status; low = chip in reset
start  in  1  one-cycle run request
chan_sel  in  2  0 = round-robin noc1..3; 1/2/3 = fixed noc1/2/3
hdr_tmpl  in  NOC_DATA_WIDTH  flit template (chipid/x/y/fbits/len/msgtype)
tx_data  out  NOC_DATA_WIDTH  flit to chip, shared by all channels
tx_val  out  3  one-hot valid, bit0 = noc1
tx_rdy  in  3  chip ready per channel
rx_data  in  3*NOC_DATA_WIDTH  returned flits, [W-1:0] = noc1
rx_val  in  3  returned-flit valid per channel
rx_rdy  out  3  one-hot ready to chip
busy  out  1  run in progress
done  out  1  run finished (sticky until next start)
pass  out  1  valid when done
err_code  out  2  0 none, 1 timeout, 2 sequence mismatch, 3 chip reset
tx_cnt  out  CNT_W  flits accepted by chip
rx_cnt  out  CNT_W  flits received

Behaviour:
- Reset values: all outputs 0, state IDLE; tx_data = 0.
- States: IDLE, SEND, DRAIN, DONE.
- IDLE:
  - start && chip_rst_n: latch chan_sel, clear counters/err, go to SEND. tx_val is high in the next cycle (1-cycle latency).
  - start && !chip_rst_n: go to DONE, err=3, pass=0.
- SEND:
  - tx_data = hdr_tmpl with bits [13:6] (MSHR field) replaced by tx_cnt[7:0].
  - Channel for flit i: fixed mode uses latched chan_sel; RR mode uses (i mod 3)+1.
  - tx_val stays high with tx_data stable until the selected tx_rdy bit is high; val&rdy = accept, tx_cnt++.
  - Accepting flit NUM_PKTS-1 -> DRAIN. tx_rdy on non-selected channels is ignored.
- rx (SEND and DRAIN):
  - Fixed priority noc1 > noc2 > noc3; rx_rdy is one-hot on the highest-priority valid channel, 0 otherwise.
  - On accept, compare rx_data[13:6] with rx_cnt[7:0]:
    - Equal: rx_cnt++.
    - Mismatch: DONE, err=2.
  - rx_rdy is 0 in IDLE/DONE.
- Same-cycle tx accept and rx accept: both counters update independently.
- DRAIN: rx_cnt == NUM_PKTS -> DONE, pass=1.
- Timeout: counter clears on any tx or rx accept and on entry to SEND; increments otherwise in SEND/DRAIN. Reaching TIMEOUT_CYCLES-1 -> DONE, err=1.
- Error precedence in one cycle: chip reset (3) > mismatch (2) > timeout (1).
- chip_rst_n low during SEND/DRAIN -> DONE next cycle, err=3, tx_val/rx_rdy drop immediately (combinational gate).
- DONE:
  - busy=0, done=1; counters hold.
  - start restarts exactly as from IDLE (done clears the same cycle busy rises).
- start while busy: ignored.
- busy=1 in SEND/DRAIN only.
- chipset_rst_n assertion mid-run: all state to reset values immediately; no flit is held.
- Counters: CNT_W-bit, never wrap (NUM_PKTS ≤ 2^CNT_W-1).

Decomposition:
- Package polara_noc_test_pkg: state encoding, ERR_NONE/TIMEOUT/SEQ/CHIPRST, MSHR_LSB=6, MSHR_MSB=13, channel one-hot constants.
- Sub-module polara_rx_prio_sel: 3-way fixed-priority one-hot select of rx_val → rx_rdy plus data mux.

Test Plan:
- Fixed noc2, NUM_PKTS=4, tx_rdy=3'b010, chip echoes on noc2 → tx_val=3'b010 ×4, tags 0..3, rx_cnt=4, done=1, pass=1, err=0.
- RR mode, NUM_PKTS=6, all ready → tx_val sequence 001,010,100,001,010,100; echoes returned → pass=1.
- tx_rdy low 5 cycles on flit 2 → tx_val/tx_data held stable 5 cycles, tx_cnt stays 2, then accepted.
- Echo tags 0,2 (skip 1) → after 2nd rx accept: done=1, pass=0, err_code=2, rx_cnt=1.
- No echoes, TIMEOUT_CYCLES=16 → DONE 16 cycles after last tx accept, err_code=1.
- chip_rst_n low during SEND → tx_val=0 same cycle, next cycle err_code=3; start while busy produces no effect.
